// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 slave memory responder.
// Holds the response codes, burst codes and FSM state encodings.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for one AXI burst: FIXED holds, every other burst type
// (WRAP and reserved included) advances by one beat size.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADR_WID = 32
) (
  input  logic [ADR_WID-1:0] addr,
  input  logic [2:0]         size,
  input  logic [1:0]         burst,
  output logic [ADR_WID-1:0] next_addr
);

  always_comb begin
    next_addr = addr;
    if (burst != BURST_FIXED) begin
      next_addr = addr + (ADR_WID'(1) << size);
    end
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed memory; one outstanding burst per path.
// Optional start-address range checking is enabled by AXI_SLV_RANGE_CHK_EN.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int DATA_WID  = 64,
  parameter int ADR_WID   = 32,
  parameter int ID_WID    = 8,
  parameter int LEN_WID   = 8,
  parameter int MEM_DEPTH = 1024,
  parameter int STRB_WID  = DATA_WID / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WID-1:0]   AWID_a,
  input  logic [ADR_WID-1:0]  AWADDR_a,
  input  logic [LEN_WID-1:0]  AWLEN_a,
  input  logic [2:0]          AWSIZE_a,
  input  logic [1:0]          AWBURST_a,
  input  logic                AWVALID_a,
  output logic                AWREADY_a,
  input  logic [DATA_WID-1:0] WDATA_a,
  input  logic [STRB_WID-1:0] WSTRB_a,
  input  logic                WLAST_a,
  input  logic                WVALID_a,
  output logic                WREADY_a,
  output logic [ID_WID-1:0]   BID_a,
  output logic [1:0]          BRESP_a,
  output logic                BVALID_a,
  input  logic                BREADY_a,
  input  logic [ID_WID-1:0]   ARID_a,
  input  logic [ADR_WID-1:0]  ARADDR_a,
  input  logic [LEN_WID-1:0]  ARLEN_a,
  input  logic [2:0]          ARSIZE_a,
  input  logic [1:0]          ARBURST_a,
  input  logic                ARVALID_a,
  output logic                ARREADY_a,
  output logic [ID_WID-1:0]   RID_a,
  output logic [DATA_WID-1:0] RDATA_a,
  output logic [1:0]          RRESP_a,
  output logic                RLAST_a,
  output logic                RVALID_a,
  input  logic                RREADY_a
);

  localparam int OFF_W = $clog2(STRB_WID);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = LEN_WID + 1;

  wr_state_e           wr_state_q, wr_state_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WID-1:0]   wr_id_q, wr_id_d;
  logic [ADR_WID-1:0]  wr_addr_q, wr_addr_d, wr_addr_next;
  logic [LEN_WID-1:0]  wr_len_q, wr_len_d;
  logic [2:0]          wr_size_q, wr_size_d;
  logic [1:0]          wr_burst_q, wr_burst_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                wr_err_q, wr_err_d, wr_oor_q, wr_oor_d;

  rd_state_e           rd_state_q, rd_state_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [ID_WID-1:0]   rd_id_q, rd_id_d;
  logic [ADR_WID-1:0]  rd_addr_q, rd_addr_d, rd_addr_next;
  logic [LEN_WID-1:0]  rd_len_q, rd_len_d;
  logic [2:0]          rd_size_q, rd_size_d;
  logic [1:0]          rd_burst_q, rd_burst_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                rd_oor_q, rd_oor_d;

  logic [DATA_WID-1:0] mem [MEM_DEPTH];
  logic [DATA_WID-1:0] rdata_q;
  logic [IDX_W-1:0]    mem_ridx;
  logic                mem_re, mem_we, w_beat, w_final, aw_oor, ar_oor;

`ifdef AXI_SLV_RANGE_CHK_EN
  localparam logic [ADR_WID:0] MEM_BYTES = (ADR_WID+1)'(MEM_DEPTH * STRB_WID);
  assign aw_oor = {1'b0, AWADDR_a} >= MEM_BYTES;
  assign ar_oor = {1'b0, ARADDR_a} >= MEM_BYTES;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  axi4_burst_addr_gen #(.ADR_WID(ADR_WID)) u_wr_addr_gen (
    .addr(wr_addr_q), .size(wr_size_q), .burst(wr_burst_q), .next_addr(wr_addr_next)
  );
  axi4_burst_addr_gen #(.ADR_WID(ADR_WID)) u_rd_addr_gen (
    .addr(rd_addr_q), .size(rd_size_q), .burst(rd_burst_q), .next_addr(rd_addr_next)
  );

  // The burst always ends on the beat count; WLAST only feeds the error flag.
  assign w_final = (wr_cnt_q == {1'b0, wr_len_q});

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_oor_d   = wr_oor_q;
    w_beat     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID_a && awready_q) begin
          wr_id_d    = AWID_a;
          wr_addr_d  = AWADDR_a;
          wr_len_d   = AWLEN_a;
          wr_size_d  = AWSIZE_a;
          wr_burst_d = AWBURST_a;
          wr_cnt_d   = '0;
          wr_err_d   = aw_oor;
          wr_oor_d   = aw_oor;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID_a && wready_q) begin
          w_beat    = 1'b1;
          wr_addr_d = wr_addr_next;
          wr_cnt_d  = wr_cnt_q + CNT_W'(1);
          if (WLAST_a != w_final) wr_err_d = 1'b1;
          if (w_final) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = wr_err_d ? RESP_SLVERR : RESP_OKAY;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY_a && bvalid_q) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      wr_oor_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      wr_oor_q   <= wr_oor_d;
    end
  end

  // Read data is fetched one beat ahead so RDATA is ready together with RVALID.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rd_cnt_d   = rd_cnt_q;
    rd_oor_d   = rd_oor_q;
    mem_re     = 1'b0;
    mem_ridx   = rd_addr_next[OFF_W +: IDX_W];
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID_a && arready_q) begin
          rd_id_d    = ARID_a;
          rd_addr_d  = ARADDR_a;
          rd_len_d   = ARLEN_a;
          rd_size_d  = ARSIZE_a;
          rd_burst_d = ARBURST_a;
          rd_cnt_d   = '0;
          rd_oor_d   = ar_oor;
          rresp_d    = ar_oor ? RESP_SLVERR : RESP_OKAY;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rlast_d    = (ARLEN_a == '0);
          mem_re     = 1'b1;
          mem_ridx   = ARADDR_a[OFF_W +: IDX_W];
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && RREADY_a) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_next;
            rd_cnt_d  = rd_cnt_q + CNT_W'(1);
            rlast_d   = (rd_cnt_d == {1'b0, rd_len_q});
            mem_re    = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= '0;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_cnt_q   <= '0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  assign mem_we = w_beat && !wr_oor_q && !rst;

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_WID; b++) begin
      if (mem_we && WSTRB_a[b]) begin
        mem[wr_addr_q[OFF_W +: IDX_W]][b*8 +: 8] <= WDATA_a[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem[mem_ridx];
    end
  end

  assign AWREADY_a = awready_q;
  assign WREADY_a  = wready_q;
  assign BVALID_a  = bvalid_q;
  assign BRESP_a   = bresp_q;
  assign BID_a     = wr_id_q;
  assign ARREADY_a = arready_q;
  assign RVALID_a  = rvalid_q;
  assign RLAST_a   = rlast_q;
  assign RRESP_a   = rresp_q;
  assign RID_a     = rd_id_q;
  assign RDATA_a   = rd_oor_q ? '0 : rdata_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: directed scenarios plus randomized
// bursts checked against a byte-level memory model kept in the bench.
module tb_axi4_slave_mem;

  localparam int DEPTH = 1024;
  localparam int SW    = 8;
`ifdef AXI_SLV_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  AWID_a = '0, ARID_a = '0, BID_a, RID_a;
  logic [31:0] AWADDR_a = '0, ARADDR_a = '0;
  logic [7:0]  AWLEN_a = '0, ARLEN_a = '0;
  logic [2:0]  AWSIZE_a = '0, ARSIZE_a = '0;
  logic [1:0]  AWBURST_a = '0, ARBURST_a = '0, BRESP_a, RRESP_a;
  logic        AWVALID_a = 1'b0, AWREADY_a, WLAST_a = 1'b0, WVALID_a = 1'b0, WREADY_a;
  logic [63:0] WDATA_a = '0, RDATA_a;
  logic [7:0]  WSTRB_a = '0;
  logic        BVALID_a, BREADY_a = 1'b0, ARVALID_a = 1'b0, ARREADY_a;
  logic        RLAST_a, RVALID_a, RREADY_a = 1'b0;

  always #5 clk = ~clk;

  axi4_slave_mem dut (
    .clk(clk), .rst(rst),
    .AWID_a(AWID_a), .AWADDR_a(AWADDR_a), .AWLEN_a(AWLEN_a), .AWSIZE_a(AWSIZE_a),
    .AWBURST_a(AWBURST_a), .AWVALID_a(AWVALID_a), .AWREADY_a(AWREADY_a),
    .WDATA_a(WDATA_a), .WSTRB_a(WSTRB_a), .WLAST_a(WLAST_a), .WVALID_a(WVALID_a),
    .WREADY_a(WREADY_a), .BID_a(BID_a), .BRESP_a(BRESP_a), .BVALID_a(BVALID_a),
    .BREADY_a(BREADY_a), .ARID_a(ARID_a), .ARADDR_a(ARADDR_a), .ARLEN_a(ARLEN_a),
    .ARSIZE_a(ARSIZE_a), .ARBURST_a(ARBURST_a), .ARVALID_a(ARVALID_a),
    .ARREADY_a(ARREADY_a), .RID_a(RID_a), .RDATA_a(RDATA_a), .RRESP_a(RRESP_a),
    .RLAST_a(RLAST_a), .RVALID_a(RVALID_a), .RREADY_a(RREADY_a)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];
  logic [63:0] rbuf [256];
  logic [1:0]  rresp_buf [256];
  logic        rlast_buf [256];
  logic [1:0]  last_bresp;
  logic [7:0]  last_bid, last_rid;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                            input logic [2:0] sz, input logic [1:0] bu);
    if (bu == 2'b00) return a;
    return a + (32'(k) << sz);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return !RANGE_CHK || (a < 32'(DEPTH * SW));
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [7:0] id,
                          input int early_last, input bit drop_last);
    int n;
    AWID_a = id; AWADDR_a = addr; AWLEN_a = 8'(len); AWSIZE_a = sz; AWBURST_a = bu;
    AWVALID_a = 1'b1;
    n = 0;
    while (!AWREADY_a && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY_a);
      AWVALID_a = 1'b0;
      return;
    end
    @(posedge clk); #1;
    AWVALID_a = 1'b0;
    for (int k = 0; k <= len; k++) begin
      WDATA_a = wbuf[k]; WSTRB_a = sbuf[k];
      WLAST_a = drop_last ? 1'b0 : ((k == len) || (k == early_last));
      WVALID_a = 1'b1;
      n = 0;
      while (!WREADY_a && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
        checks++; errors++;
        $display("FAIL w_timeout: beat %0d WREADY=%b required 1", k, WREADY_a);
        WVALID_a = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (in_range(addr)) begin
        for (int b = 0; b < SW; b++)
          if (sbuf[k][b]) model[widx(beat_addr(addr, k, sz, bu))][b*8 +: 8] = wbuf[k][b*8 +: 8];
      end
    end
    WVALID_a = 1'b0; WLAST_a = 1'b0;
    checks++;
    if (BVALID_a !== 1'b1) begin
      errors++;
      $display("FAIL b_latency: BVALID=%b one cycle after last W beat, required 1", BVALID_a);
    end
    n = 0;
    while (!BVALID_a && n < 50) begin @(posedge clk); #1; n++; end
    last_bresp = BRESP_a; last_bid = BID_a;
    BREADY_a = 1'b1;
    @(posedge clk); #1;
    BREADY_a = 1'b0;
    checks++;
    if (BVALID_a !== 1'b0) begin
      errors++;
      $display("FAIL b_drop: BVALID=%b after B handshake, required 0", BVALID_a);
    end
    $display("WRITE addr=%h len=%0d size=%0d burst=%0d id=%h bresp=%0d",
             addr, len, sz, bu, id, last_bresp);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [7:0] id, input bit toggle);
    int n, k, cyc;
    bit held;
    logic [74:0] hv;
    ARID_a = id; ARADDR_a = addr; ARLEN_a = 8'(len); ARSIZE_a = sz; ARBURST_a = bu;
    ARVALID_a = 1'b1;
    n = 0;
    while (!ARREADY_a && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY_a);
      ARVALID_a = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ARVALID_a = 1'b0;
    checks++;
    if (RVALID_a !== 1'b1) begin
      errors++;
      $display("FAIL r_latency: RVALID=%b after AR handshake, required 1", RVALID_a);
    end
    k = 0; cyc = 0; held = 0; hv = '0;
    while (k <= len && cyc < 2000) begin
      if (RVALID_a) begin
        if (held) begin
          checks++;
          if ({RDATA_a, RLAST_a, RRESP_a, RID_a} !== hv) begin
            errors++;
            $display("FAIL r_stall_hold: beat %0d R=%h required %h", k,
                     {RDATA_a, RLAST_a, RRESP_a, RID_a}, hv);
          end
        end
        RREADY_a = toggle ? cyc[0] : 1'b1;
        if (RREADY_a) begin
          rbuf[k] = RDATA_a; rresp_buf[k] = RRESP_a; rlast_buf[k] = RLAST_a;
          last_rid = RID_a; k++; held = 0;
        end else begin
          held = 1; hv = {RDATA_a, RLAST_a, RRESP_a, RID_a};
        end
      end else begin
        RREADY_a = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    RREADY_a = 1'b0;
    checks++;
    if (k <= len) begin
      errors++;
      $display("FAIL r_timeout: %0d beats received, required %0d", k, len + 1);
    end else if (RVALID_a !== 1'b0) begin
      errors++;
      $display("FAIL r_end: RVALID=%b after last beat, required 0", RVALID_a);
    end
    $display("READ  addr=%h len=%0d size=%0d burst=%0d id=%h beats=%0d",
             addr, len, sz, bu, id, k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a, RLAST_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready/valid=%b required 000000",
               {AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a, RLAST_a});
    end
    checks++;
    if ({BID_a, BRESP_a, RID_a, RRESP_a, RDATA_a} !== 84'b0) begin
      errors++;
      $display("FAIL reset_data: B/R fields=%h required 0",
               {BID_a, BRESP_a, RID_a, RRESP_a, RDATA_a});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({AWREADY_a, ARREADY_a} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: AWREADY/ARREADY=%b required 11", {AWREADY_a, ARREADY_a});
    end
  endtask

  task automatic test_preload();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 256; k++) begin
        wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF;
      end
      do_write(32'(c * 256 * SW), 255, 3'd3, 2'b01, 8'(c), -1, 1'b0);
      checks++;
      if (last_bresp !== 2'b00) begin
        errors++;
        $display("FAIL preload_bresp: chunk %0d BRESP=%0d required 0", c, last_bresp);
      end
    end
  endtask

  task automatic test_single_write();
    wbuf[0] = 64'hA5A5_0000_1234_5678; sbuf[0] = 8'hFF;
    do_write(32'h10, 0, 3'd3, 2'b01, 8'h3C, -1, 1'b0);
    checks++;
    if ({last_bid, last_bresp} !== {8'h3C, 2'b00}) begin
      errors++;
      $display("FAIL single_b: BID/BRESP=%h/%0d required 3c/0", last_bid, last_bresp);
    end
    do_read(32'h10, 0, 3'd3, 2'b01, 8'h5A, 1'b0);
    checks++;
    if ({rbuf[0], rlast_buf[0], rresp_buf[0], last_rid} !== {64'hA5A5_0000_1234_5678, 1'b1, 2'b00, 8'h5A}) begin
      errors++;
      $display("FAIL single_r: data=%h last=%b resp=%0d id=%h required a5a5000012345678/1/0/5a",
               rbuf[0], rlast_buf[0], rresp_buf[0], last_rid);
    end
  endtask

  task automatic test_incr_burst();
    for (int k = 0; k < 4; k++) begin wbuf[k] = 64'(k + 1); sbuf[k] = 8'hFF; end
    do_write(32'h100, 3, 3'd3, 2'b01, 8'h11, -1, 1'b0);
    do_read(32'h100, 3, 3'd3, 2'b01, 8'h22, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rbuf[k], rlast_buf[k]} !== {64'(k + 1), (k == 3)}) begin
        errors++;
        $display("FAIL incr_beat%0d: data=%h last=%b required %h/%b",
                 k, rbuf[k], rlast_buf[k], 64'(k + 1), (k == 3));
      end
    end
  endtask

  task automatic test_strobes();
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
    do_write(32'h200, 0, 3'd3, 2'b01, 8'h01, -1, 1'b0);
    wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
    do_write(32'h200, 0, 3'd3, 2'b01, 8'h02, -1, 1'b0);
    do_read(32'h200, 0, 3'd3, 2'b01, 8'h03, 1'b0);
    checks++;
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000) begin
      errors++;
      $display("FAIL strobe: data=%h required ffffffff00000000", rbuf[0]);
    end
  endtask

  task automatic test_fixed();
    wbuf[0] = 64'd7; wbuf[1] = 64'd8; wbuf[2] = 64'd9;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF; sbuf[2] = 8'hFF;
    do_write(32'h20, 2, 3'd3, 2'b00, 8'h44, -1, 1'b0);
    do_read(32'h20, 0, 3'd3, 2'b01, 8'h45, 1'b0);
    checks++;
    if (rbuf[0] !== 64'd9) begin
      errors++;
      $display("FAIL fixed: data=%h required 9", rbuf[0]);
    end
  endtask

  task automatic test_wlast_err();
    for (int k = 0; k < 4; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
    do_write(32'h400, 3, 3'd3, 2'b01, 8'h77, 1, 1'b0);
    checks++;
    if ({last_bid, last_bresp} !== {8'h77, 2'b10}) begin
      errors++;
      $display("FAIL wlast_early: BID/BRESP=%h/%0d required 77/2", last_bid, last_bresp);
    end
    do_read(32'h400, 3, 3'd3, 2'b01, 8'h78, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rbuf[k] !== wbuf[k]) begin
        errors++;
        $display("FAIL wlast_data%0d: data=%h required %h", k, rbuf[k], wbuf[k]);
      end
    end
    do_write(32'h400, 3, 3'd3, 2'b01, 8'h79, -1, 1'b1);
    checks++;
    if (last_bresp !== 2'b10) begin
      errors++;
      $display("FAIL wlast_missing: BRESP=%0d required 2", last_bresp);
    end
    do_write(32'h400, 3, 3'd3, 2'b01, 8'h7A, -1, 1'b0);
    checks++;
    if (last_bresp !== 2'b00) begin
      errors++;
      $display("FAIL wlast_clean: BRESP=%0d required 0", last_bresp);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    AWID_a = 8'h99; AWADDR_a = 32'h300; AWLEN_a = 8'd3; AWSIZE_a = 3'd3; AWBURST_a = 2'b01;
    AWVALID_a = 1'b1;
    n = 0;
    while (!AWREADY_a && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    AWVALID_a = 1'b0;
    WDATA_a = {$urandom, $urandom}; WSTRB_a = 8'hFF; WLAST_a = 1'b0; WVALID_a = 1'b1;
    n = 0;
    while (!WREADY_a && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    model[widx(32'h300)] = WDATA_a;
    WVALID_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid: ready/valid=%b required 00000",
               {AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({AWREADY_a, BVALID_a} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release: AWREADY/BVALID=%b required 10", {AWREADY_a, BVALID_a});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (BVALID_a !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_b: BVALID=%b cycle %0d after reset, required 0", BVALID_a, i);
      end
    end
    do_read(32'h300, 0, 3'd3, 2'b01, 8'h9A, 1'b0);
    checks++;
    if (rbuf[0] !== model[widx(32'h300)]) begin
      errors++;
      $display("FAIL rst_beat0: data=%h required %h", rbuf[0], model[widx(32'h300)]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [1:0]  bu;
    logic [7:0]  id;
    logic [63:0] exp;
    int len;
    for (int it = 0; it < 30; it++) begin
      addr = 32'($urandom_range(0, DEPTH * SW - 1));
      len  = int'($urandom_range(0, 15));
      sz   = 3'($urandom_range(0, 3));
      bu   = 2'($urandom_range(0, 3));
      id   = 8'($urandom);
      for (int k = 0; k <= len; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'($urandom); end
      do_write(addr, len, sz, bu, id, -1, 1'b0);
      checks++;
      if ({last_bid, last_bresp} !== {id, 2'b00}) begin
        errors++;
        $display("FAIL rand_b%0d: BID/BRESP=%h/%0d required %h/0", it, last_bid, last_bresp, id);
      end
      do_read(addr, len, sz, bu, ~id, 1'($urandom));
      for (int k = 0; k <= len; k++) begin
        exp = model[widx(beat_addr(addr, k, sz, bu))];
        checks++;
        if ({rbuf[k], rresp_buf[k], rlast_buf[k]} !== {exp, 2'b00, (k == len)}) begin
          errors++;
          $display("FAIL rand_r%0d_%0d: data=%h resp=%0d last=%b required %h/0/%b",
                   it, k, rbuf[k], rresp_buf[k], rlast_buf[k], exp, (k == len));
        end
      end
    end
  endtask

  task automatic test_range();
    do_read(32'h8000, 1, 3'd3, 2'b01, 8'h61, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (RANGE_CHK) begin
        if ({rbuf[k], rresp_buf[k]} !== {64'h0, 2'b10}) begin
          errors++;
          $display("FAIL range_r%0d: data=%h resp=%0d required 0/2", k, rbuf[k], rresp_buf[k]);
        end
      end else if ({rbuf[k], rresp_buf[k]} !== {model[k], 2'b00}) begin
        errors++;
        $display("FAIL wrap_r%0d: data=%h resp=%0d required %h/0", k, rbuf[k], rresp_buf[k], model[k]);
      end
    end
    wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
    do_write(32'h8008, 0, 3'd3, 2'b01, 8'h62, -1, 1'b0);
    checks++;
    if (last_bresp !== (RANGE_CHK ? 2'b10 : 2'b00)) begin
      errors++;
      $display("FAIL range_b: BRESP=%0d required %0d", last_bresp, RANGE_CHK ? 2 : 0);
    end
    do_read(32'h8, 0, 3'd3, 2'b01, 8'h63, 1'b0);
    checks++;
    if (rbuf[0] !== model[1]) begin
      errors++;
      $display("FAIL range_mem: data=%h required %h", rbuf[0], model[1]);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_write();
    test_incr_burst();
    test_strobes();
    test_fixed();
    test_wlast_err();
    test_reset_mid();
    test_random();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- AXI4 slave memory responder that sits directly downstream of the AXI master.
- Consumes the AW/W/AR channels and produces the B/R channels, backed by a word-addressed internal memory array.
- Serves as the bench-side and FPGA loopback target, so the FIFO-to-decoder-to-master path runs end-to-end without an external interconnect.
- Write and read paths are independent; each path has one outstanding burst.

Parameters:
- DATA_WID, 64, data bus width
- ADR_WID, 32, address width
- ID_WID, 8, transaction ID width
- LEN_WID, 8, burst length width
- MEM_DEPTH, 1024, memory depth in DATA_WID words (power of 2)
- STRB_WID, DATA_WID/8, write strobe width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AWID_a  in  ID_WID  write ID
- AWADDR_a  in  ADR_WID  write start address
- AWLEN_a  in  LEN_WID  write beats minus 1
- AWSIZE_a  in  3  write beat size
- AWBURST_a  in  2  write burst type
- AWVALID_a  in  1  write address valid
- AWREADY_a  out  1  write address ready
- WDATA_a  in  DATA_WID  write data
- WSTRB_a  in  STRB_WID  byte enables
- WLAST_a  in  1  last write beat
- WVALID_a  in  1  write data valid
- WREADY_a  out  1  write data ready
- BID_a  out  ID_WID  write response ID
- BRESP_a  out  2  write response
- BVALID_a  out  1  write response valid
- BREADY_a  in  1  write response ready
- ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a  in  (widths as AW)  read address channel
- ARREADY_a  out  1  read address ready
- RID_a  out  ID_WID  read ID
- RDATA_a  out  DATA_WID  read data
- RRESP_a  out  2  read response
- RLAST_a  out  1  last read beat
- RVALID_a  out  1  read data valid
- RREADY_a  in  1  read data ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0. Both FSMs go to idle. Memory contents are not cleared.
- Reset mid-operation: the in-flight burst is abandoned with no B or R response issued.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY_a is 1 from the first cycle after reset is released.
  - On the AW handshake, latch ID, address, length, size and burst type; go to W_DATA. AWREADY_a drops in the next cycle.
  - W_DATA: WREADY_a is 1. Each WVALID_a beat writes the bytes enabled by WSTRB_a, then advances the address and increments the beat counter.
  - After beat AWLEN+1, go to W_RESP.
  - WLAST_a mismatch (asserted early, or absent on the final beat) sets an error flag. The burst still ends on the beat count.
  - W_RESP: BVALID_a=1, BID_a=latched ID, BRESP_a=OKAY (2'b00), or SLVERR (2'b10) if the error flag is set. Hold until BREADY_a, then go to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY_a is 1. On the AR handshake, latch the request and go to R_DATA.
  - R_DATA: RVALID_a=1 in the cycle after the AR handshake. RDATA_a=mem[current index], RID_a=latched ID, RRESP_a=OKAY. RLAST_a=1 on beat ARLEN+1.
  - All R outputs hold stable while RREADY_a=0. A beat advances on RVALID_a&&RREADY_a.
  - After the last beat, go to R_IDLE.
- Addressing:
  - index = addr[log2(STRB_WID) +: log2(MEM_DEPTH)]. Out-of-range addresses wrap modulo MEM_DEPTH.
  - FIXED (2'b00): address does not change.
  - INCR (2'b01): address += 1<<size per beat.
  - WRAP (2'b10) and reserved (2'b11) are treated as INCR.
- Beat counters are LEN_WID+1 bits wide, so AWLEN=255 gives 256 beats with no overflow.
- Same-cycle write and read to the same index: the read returns the old data.

Optional Feature:
- Macro: AXI_SLV_RANGE_CHK_EN.
- Defined: a burst whose start address ≥ MEM_DEPTH*STRB_WID gets SLVERR.
  - Writes: data is discarded and BRESP_a=2'b10.
  - Reads: RDATA_a=0 and RRESP_a=2'b10 on every beat.
- Undefined: out-of-range addresses wrap as described above and always return OKAY.

Decomposition:
- Shared package axi4_pkg:
  - response codes RESP_OKAY / RESP_SLVERR
  - burst codes BURST_FIXED / BURST_INCR / BURST_WRAP
  - FSM state encodings
- Sub-module axi4_burst_addr_gen: computes the next address from (addr, size, burst). Instantiated once for the write path and once for the read path.

Test Plan:
- Single write: AW addr 0x10, len 0, strb 0xFF, data 0xA5A5_0000_1234_5678 -> BVALID one cycle after the W beat, BRESP=0, BID=AWID. Read back at 0x10 -> same data, RLAST=1.
- INCR burst: write len 3 at 0x100 with data 1..4, then read len 3 with RREADY toggling every cycle -> RDATA 1,2,3,4 held stable across stalls, RLAST only on the 4th beat.
- Byte strobes: preload 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- FIXED burst: write len 2 at 0x20 with data 7,8,9 -> read at 0x20 returns 9.
- WLAST early on beat 1 of a len-3 burst -> 4 beats accepted, BRESP=2'b10.
- Reset asserted during W_DATA -> all outputs 0 the next cycle, AWREADY=1 after release, no BVALID. With AXI_SLV_RANGE_CHK_EN defined, a read at 0x8000 for MEM_DEPTH 1024 -> RRESP=2'b10 and RDATA=0.
